// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a word over a ready/valid handshake and serialises it
// as start, LSB-first data, optional parity and one or two stop bits, one bit per CLK.
module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  ready,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  stop2_q, stop2_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  last_stop;
    logic                  accept;

    assign last_stop = !stop2_q || stop_cnt_q;
    assign ready     = (state_q == StIdle) || ((state_q == StStop) && last_stop);
    assign accept    = Data_valid && ready;
    assign TX_OUT    = tx_q;
    assign busy      = busy_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        parity_d   = parity_q;
        tx_d       = 1'b1;

        if (accept) begin
            shift_d  = P_DATA;
            par_en_d = PAR_EN;
            stop2_d  = STOP2;
            parity_d = (^P_DATA) ^ PAR_TYP;
        end

        case (state_q)
            StIdle: begin
                if (accept) state_d = StStart;
            end
            StStart: begin
                state_d = StData;
                cnt_d   = '0;
            end
            StData: begin
                if (cnt_q == LastBit) begin
                    cnt_d      = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = par_en_q ? StParity : StStop;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    shift_d = shift_q >> 1;
                end
            end
            StParity: begin
                state_d    = StStop;
                stop_cnt_d = 1'b0;
            end
            StStop: begin
                if (last_stop) begin
                    state_d    = accept ? StStart : StIdle;
                    stop_cnt_d = 1'b0;
                end else begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is registered, so it is derived from the state being entered.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_q;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            cnt_q      <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: 8-bit and 5-bit instances, expected line bits queued per frame.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] p_data;
    logic       dv, par_en, par_typ, stop2;
    logic       ready, tx, busy;
    logic [4:0] p_data5;
    logic       dv5, par_en5, par_typ5, stop25;
    logic       ready5, tx5, busy5;

    int n_vec = 0;
    int n_err = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK(clk), .RST(rst_n), .P_DATA(p_data), .Data_valid(dv), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .STOP2(stop2), .ready(ready), .TX_OUT(tx), .busy(busy)
    );

    uart_tx_ctrl #(.DATA_WIDTH(5)) dut5 (
        .CLK(clk), .RST(rst_n), .P_DATA(p_data5), .Data_valid(dv5), .PAR_EN(par_en5),
        .PAR_TYP(par_typ5), .STOP2(stop25), .ready(ready5), .TX_OUT(tx5), .busy(busy5)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line bits for one frame.
    task automatic push_frame(input logic [8:0] d, input int w, input logic pe, input logic pt,
                              input logic s2);
        logic p;
        p = pt;
        exp_q.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (pe) exp_q.push_back(p);
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_vec++;
        if ({tx, busy, ready} !== 3'b101) begin
            n_err++;
            $display("FAIL reset8 got tx/busy/ready=%b required 101", {tx, busy, ready});
        end
        n_vec++;
        if ({tx5, busy5, ready5} !== 3'b101) begin
            n_err++;
            $display("FAIL reset5 got tx/busy/ready=%b required 101", {tx5, busy5, ready5});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic pe,
                             input logic pt, input logic s2);
        int   n;
        logic e;
        push_frame({1'b0, d}, 8, pe, pt, s2);
        n = exp_q.size();
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_ready got %b required 1", name, ready);
        end
        p_data = d; par_en = pe; par_typ = pt; stop2 = s2; dv = 1'b1;
        step();
        // Mid-frame input changes must not affect the frame in flight.
        dv = 1'b0; p_data = ~d; par_en = ~pe; par_typ = ~pt; stop2 = ~s2;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({busy, tx} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL %s_bit%0d got busy/tx=%b%b required 1%b", name, i, busy, tx, e);
            end
            step();
        end
        n_vec++;
        if ({tx, busy, ready} !== 3'b101) begin
            n_err++;
            $display("FAIL %s_end got tx/busy/ready=%b required 101", name, {tx, busy, ready});
        end
    endtask

    task automatic test_even_parity();
        run_frame("even_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_odd_parity();
        run_frame("odd_a5", 8'hA5, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_two_stop();
        run_frame("stop2_0f", 8'h0F, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int   n;
        logic e;
        push_frame(9'h001, 8, 1'b0, 1'b0, 1'b0);
        push_frame(9'h0FF, 8, 1'b0, 1'b0, 1'b0);
        n = exp_q.size();
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; p_data = 8'h01; dv = 1'b1;
        step();
        for (int i = 1; i <= n; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({busy, tx} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL b2b_bit%0d got busy/tx=%b%b required 1%b", i, busy, tx, e);
            end
            n_vec++;
            if (ready !== ((i == 10) || (i == 20))) begin
                n_err++;
                $display("FAIL b2b_ready%0d got %b required %b", i, ready,
                         ((i == 10) || (i == 20)));
            end
            if (i < 10) p_data = 8'($urandom);
            else if (i == 10) p_data = 8'hFF;
            else begin
                dv = 1'b0;
                p_data = 8'($urandom);
            end
            step();
        end
        n_vec++;
        if ({tx, busy, ready} !== 3'b101) begin
            n_err++;
            $display("FAIL b2b_end got tx/busy/ready=%b required 101", {tx, busy, ready});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic e;
        push_frame(9'h0A5, 8, 1'b1, 1'b0, 1'b0);
        p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; dv = 1'b1;
        step();
        dv = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({busy, tx} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL rstmid_bit%0d got busy/tx=%b%b required 1%b", i, busy, tx, e);
            end
            if (i == 5) rst_n = 1'b0;
            step();
        end
        exp_q.delete();
        n_vec++;
        if ({tx, busy, ready} !== 3'b101) begin
            n_err++;
            $display("FAIL rstmid_abort got tx/busy/ready=%b required 101", {tx, busy, ready});
        end
        rst_n = 1'b1;
        step();
        run_frame("after_rst_3c", 8'h3C, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_width5();
        int   n;
        logic e;
        push_frame(9'h013, 5, 1'b1, 1'b0, 1'b0);
        n = exp_q.size();
        n_vec++;
        if (n != 8) begin
            n_err++;
            $display("FAIL w5_len got %0d required 8", n);
        end
        p_data5 = 5'h13; par_en5 = 1'b1; par_typ5 = 1'b0; stop25 = 1'b0; dv5 = 1'b1;
        step();
        dv5 = 1'b0; p_data5 = 5'h0C; par_typ5 = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({busy5, tx5} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL w5_bit%0d got busy/tx=%b%b required 1%b", i, busy5, tx5, e);
            end
            step();
        end
        n_vec++;
        if ({tx5, busy5, ready5} !== 3'b101) begin
            n_err++;
            $display("FAIL w5_end got tx/busy/ready=%b required 101", {tx5, busy5, ready5});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        p_data = '0; dv = 1'b0; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
        p_data5 = '0; dv5 = 1'b0; par_en5 = 1'b0; par_typ5 = 1'b0; stop25 = 1'b0;
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
        test_width5();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
